regfile_write_arbiter: RTL and testbench

Arbitrates N writeback requesters (ALU writeback, load writeback, and so on) for the single write port of the register file (`we3`/`a3`/`wd3`). Grants use round-robin with a valid/ready handshake. The winning request is registered and driven to the register file one cycle after acceptance. Writes to register 0 are accepted and discarded.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/regfile_write_arbiter.sv | 58 +++++
 tb/tb_regfile_write_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file writeback types and the round-robin pointer helper.
package regfile_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

    // Index after idx in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NREQ requesters; ptr marks the highest-priority index.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter  int NREQ  = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             en,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               idx;

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (en && !reset && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= IDX_W'(rr_next(int'(gnt_idx), NREQ));
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates writeback requesters onto the single register-file write port.
module regfile_write_arbiter #(
    parameter  int NREQ   = 2,
    parameter  int ADDR_W = 6,
    parameter  int DATA_W = 32,
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hold,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_a3,
    output logic [DATA_W-1:0]        rf_wd3
);

    logic [NREQ-1:0]   gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              we_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .en      (!hold),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);
    assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q   <= 1'b0;
            rf_a3  <= '0;
            rf_wd3 <= '0;
        end else if (accept) begin
            we_q   <= (sel_addr != '0);
            rf_a3  <= sel_addr;
            rf_wd3 <= sel_data;
        end else begin
            we_q   <= 1'b0;
        end
    end

    // An in-flight write must not land in the register file once reset rises.
    assign rf_we = we_q & ~reset;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed vector table, register-file readback, fairness and randomized model compare.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int N = 2;

    logic              clk = 1'b0;
    logic              reset, hold;
    logic [N-1:0]      req_valid;
    logic [N*6-1:0]    req_addr;
    logic [N*32-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              rf_we;
    logic [5:0]        rf_a3;
    logic [31:0]       rf_wd3;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.NREQ(N), .ADDR_W(6), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3)
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT write port.
    logic [31:0] mem [64] = '{default: 32'h0};
    always @(posedge clk) begin
        if (rf_we) mem[rf_a3] <= rf_wd3;
    end

    typedef struct {
        logic      rst;
        logic      hld;
        logic [1:0] vld;
        reg_addr_t a0, a1;
        reg_data_t d0, d1;
        logic [1:0] e_rdy;
        logic      e_we;
        reg_addr_t e_a3;
        reg_data_t e_wd3;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic r, input logic h, input logic [1:0] v,
                                input reg_addr_t a0, input reg_addr_t a1,
                                input reg_data_t d0, input reg_data_t d1,
                                input logic [1:0] er, input logic ew,
                                input reg_addr_t ea, input reg_data_t ed);
        vec_t t;
        t.rst = r; t.hld = h; t.vld = v; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
        t.e_rdy = er; t.e_we = ew; t.e_a3 = ea; t.e_wd3 = ed;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic h, input logic [1:0] v,
                         input reg_addr_t a0, input reg_addr_t a1,
                         input reg_data_t d0, input reg_data_t d1);
        reset     = r;
        hold      = h;
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: priority pointer plus the registered write-port contents.
    int          m_ptr;
    logic        m_we;
    reg_addr_t   m_a3;
    reg_data_t   m_wd3;

    function automatic int model_grant(input int p, input logic [1:0] v, input logic h, input logic r);
        if (r || h) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    initial begin
        int idx_t;
        int g;
        int cnt0, cnt1;
        logic [1:0] e_rdy;
        reg_addr_t a0, a1;
        reg_data_t d0, d1;

        idx_t = 0;
        tbl[idx_t++] = mk(1,0,2'b01, 5,0, 32'hDEADBEEF,0,    2'b00,0,0,0);
        tbl[idx_t++] = mk(0,0,2'b01, 5,0, 32'hDEADBEEF,0,    2'b01,0,0,0);
        tbl[idx_t++] = mk(0,0,2'b00, 0,0, 0,0,               2'b00,1,5,32'hDEADBEEF);
        tbl[idx_t++] = mk(0,0,2'b00, 0,0, 0,0,               2'b00,0,5,32'hDEADBEEF);
        tbl[idx_t++] = mk(0,0,2'b11, 1,2, 32'h11,32'h22,     2'b10,0,5,32'hDEADBEEF);
        tbl[idx_t++] = mk(0,0,2'b11, 1,2, 32'h11,32'h22,     2'b01,1,2,32'h22);
        tbl[idx_t++] = mk(0,0,2'b11, 1,2, 32'h11,32'h22,     2'b10,1,1,32'h11);
        tbl[idx_t++] = mk(0,0,2'b11, 1,2, 32'h11,32'h22,     2'b01,1,2,32'h22);
        tbl[idx_t++] = mk(0,0,2'b00, 0,0, 0,0,               2'b00,1,1,32'h11);
        tbl[idx_t++] = mk(0,0,2'b00, 0,0, 0,0,               2'b00,0,1,32'h11);
        tbl[idx_t++] = mk(0,0,2'b10, 0,0, 0,32'h1234,        2'b10,0,1,32'h11);
        tbl[idx_t++] = mk(0,0,2'b00, 0,0, 0,0,               2'b00,0,0,32'h1234);
        tbl[idx_t++] = mk(0,0,2'b00, 0,0, 0,0,               2'b00,0,0,32'h1234);
        tbl[idx_t++] = mk(0,1,2'b11, 1,2, 32'h11,32'h22,     2'b00,0,0,32'h1234);
        tbl[idx_t++] = mk(0,1,2'b11, 1,2, 32'h11,32'h22,     2'b00,0,0,32'h1234);
        tbl[idx_t++] = mk(0,1,2'b11, 1,2, 32'h11,32'h22,     2'b00,0,0,32'h1234);
        tbl[idx_t++] = mk(0,0,2'b11, 1,2, 32'h11,32'h22,     2'b01,0,0,32'h1234);
        tbl[idx_t++] = mk(0,1,2'b11, 1,2, 32'h11,32'h22,     2'b00,1,1,32'h11);
        tbl[idx_t++] = mk(0,0,2'b00, 0,0, 0,0,               2'b00,0,1,32'h11);
        tbl[idx_t++] = mk(0,0,2'b10, 0,7, 0,32'h77,          2'b10,0,1,32'h11);
        tbl[idx_t++] = mk(1,0,2'b00, 0,0, 0,0,               2'b00,0,7,32'h77);
        tbl[idx_t++] = mk(0,0,2'b00, 0,0, 0,0,               2'b00,0,0,0);
        tbl[idx_t++] = mk(0,0,2'b11, 3,3, 32'hA,32'hB,       2'b01,0,0,0);
        tbl[idx_t++] = mk(0,0,2'b10, 3,3, 32'hA,32'hB,       2'b10,1,3,32'hA);
        tbl[idx_t++] = mk(0,0,2'b00, 0,0, 0,0,               2'b00,1,3,32'hB);
        tbl[idx_t++] = mk(0,0,2'b00, 0,0, 0,0,               2'b00,0,3,32'hB);

        drive(1, 0, 2'b00, 0, 0, 0, 0);
        next_cycle();
        next_cycle();

        for (int i = 0; i < idx_t; i++) begin
            drive(tbl[i].rst, tbl[i].hld, tbl[i].vld, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("v%0d_we",    i), 64'(rf_we),     64'(tbl[i].e_we));
            chk($sformatf("v%0d_a3",    i), 64'(rf_a3),     64'(tbl[i].e_a3));
            chk($sformatf("v%0d_wd3",   i), 64'(rf_wd3),    64'(tbl[i].e_wd3));
            next_cycle();
        end

        @(negedge clk);
        chk("rf_reg3_last_writer", 64'(mem[3]), 64'hB);
        chk("rf_reg7_dropped",     64'(mem[7]), 64'h0);
        chk("rf_reg0_discarded",   64'(mem[0]), 64'h0);
        chk("rf_reg5_written",     64'(mem[5]), 64'hDEADBEEF);

        // Fairness: both continuously valid for 8 cycles.
        drive(1, 0, 2'b00, 0, 0, 0, 0);
        next_cycle();
        cnt0 = 0;
        cnt1 = 0;
        drive(0, 0, 2'b11, 9, 10, 32'h99, 32'hAA);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cnt0 += int'(req_ready[0]);
            cnt1 += int'(req_ready[1]);
            next_cycle();
        end
        chk("fair_cnt0", 64'(cnt0), 64'd4);
        chk("fair_cnt1", 64'(cnt1), 64'd4);

        // Randomized phase against the reference model.
        drive(1, 0, 2'b00, 0, 0, 0, 0);
        next_cycle();
        m_ptr = 0; m_we = 1'b0; m_a3 = '0; m_wd3 = '0;
        for (int i = 0; i < 1500; i++) begin
            a0 = reg_addr_t'($urandom_range(0, 7));
            a1 = reg_addr_t'($urandom_range(0, 63));
            d0 = $urandom;
            d1 = $urandom;
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                  2'($urandom_range(0, 3)), a0, a1, d0, d1);
            g = model_grant(m_ptr, req_valid, hold, reset);
            e_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
            @(negedge clk);
            chk("rand_ready", 64'(req_ready), 64'(e_rdy));
            chk("rand_we",    64'(rf_we),     64'(m_we & ~reset));
            chk("rand_a3",    64'(rf_a3),     64'(m_a3));
            chk("rand_wd3",   64'(rf_wd3),    64'(m_wd3));
            @(posedge clk);
            if (reset) begin
                m_ptr = 0; m_we = 1'b0; m_a3 = '0; m_wd3 = '0;
            end else if (g >= 0) begin
                m_ptr = (g + 1) % N;
                m_a3  = (g == 0) ? a0 : a1;
                m_wd3 = (g == 0) ? d0 : d1;
                m_we  = (m_a3 != 0);
            end else begin
                m_we  = 1'b0;
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
